seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4, digit count, legal range 1..8.
REQ-002 Parameter SUB_TICKS, default 3125, clk cycles per brightness sub-phase; digit slot = 16*SUB_TICKS cycles.
REQ-003 Parameter BLINK_FRAMES, default 64, frames per blink half-period, >=1.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 num  in  4*N_DIGITS  hex nibbles; nibble i drives digit i, digit 0 rightmost.
REQ-007 load  in  1  strobe; capture num, dp_in into pending shadow.
REQ-008 dp_in  in  N_DIGITS  decimal point per digit, 1 = lit.
REQ-009 digit_en  in  N_DIGITS  per-digit enable, 0 = digit dark.
REQ-010 blank_lz  in  1  leading-zero blanking enable.
REQ-011 bright  in  4  brightness, 0 = 1/16 duty, 15 = full duty.
REQ-012 blink_mask  in  N_DIGITS  digits that blink.
REQ-013 seg  out  7  segments gfedcba, active-low, registered.
REQ-014 dp_n  out  1  decimal point, active-low, registered.
REQ-015 an  out  N_DIGITS  anodes, active-low one-hot or all-ones, registered.
REQ-016 frame_done  out  1  one-cycle pulse at end of each full scan.

Function
REQ-017 Sub-counter counts 0..SUB_TICKS-1; on terminal count, phase (0..15) increments; on phase 15 terminal, digit_sel advances.
REQ-018 digit_sel wraps N_DIGITS-1 -> 0; that wrap cycle is frame end; frame_done pulses for exactly that cycle.
REQ-019 load=1 captures num/dp_in into pending; pending copies to active only at frame end (no mid-frame tearing).
REQ-020 load coincident with frame end: newly presented num/dp_in go directly to active that cycle.
REQ-021 Multiple loads in one frame: last one wins.
REQ-022 Hex decode: 0->1000000, 1->1111001, 2->0100100, 3->0110000, 4->0011001, 5->0010010, 6->0000010, 7->1111000, 8->0000000, 9->0011000, A->0001000, b->0000011, C->1000110, d->0100001, E->0000110, F->0001110.
REQ-023 Digit i (i>0) is leading-zero blank when blank_lz=1 and active nibbles i..N_DIGITS-1 are all zero; digit 0 never blanked by this rule.
REQ-024 Blink phase bit toggles every BLINK_FRAMES frame ends; digit in blink_mask dark while bit=1.
REQ-025 Digit dark when: digit_en[i]=0, leading-zero blank, blink dark, or phase > bright.
REQ-026 Dark slot: an all ones, seg 7'h7F, dp_n 1; lit slot: an bit digit_sel low only, seg decoded, dp_n = ~active dp.
REQ-027 Outputs lag internal digit_sel/phase by exactly one clk (registered).
REQ-028 bright, digit_en, blink_mask, blank_lz take effect immediately (next registered output), not shadowed.
REQ-029 N_DIGITS=1: digit_sel constant 0, frame end every 16*SUB_TICKS cycles.

Reset
REQ-030 rst=0 at rising edge: counters, phase, digit_sel, blink bit, pending, active cleared to 0.
REQ-031 During and after reset cycle: seg 7'h7F, dp_n 1, an all ones, frame_done 0.
REQ-032 Reset mid-frame discards pending load; scan restarts at digit 0, phase 0.

Structure
REQ-033 Package seg7_pkg holds SEG_OFF (7'h7F), 16-entry hex segment table, AN_OFF helper width rules.
REQ-034 Combinational sub-module seg7_decode (4-bit nibble -> 7-bit active-low segments), instanced once.

Verification
REQ-035 SUB_TICKS=2, N=4, bright=15, load num=16'h12AF: an cycles 1110,1101,1011,0111, seg 1111001? no: digit0 F->0001110, d1 A->0001000, d2 2->0100100, d3 1->1111001; frame_done every 128 cycles.
REQ-036 blank_lz=1, num=16'h0050: digits 3,2 dark (an all ones in their slots), digit1 shows 5, digit0 shows 0.
REQ-037 bright=3, SUB_TICKS=2: each digit lit 8 of 32 cycles (phases 0..3), dark remaining 24.
REQ-038 load num=16'h1111 mid-frame at digit 1: digits 1..3 still old value, new value first at next frame digit 0; load on frame-end cycle applies immediately.
REQ-039 BLINK_FRAMES=2, blink_mask=4'b0001: digit 0 lit frames 0-1, dark frames 2-3, lit frames 4-5; other digits always lit.
REQ-040 rst=0 asserted during digit 2 slot: next cycle an=4'b1111, seg=7'h7F; after release, scan resumes at digit 0 with active=0 showing 0000.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, hex segment table and counter width helper
package seg7_pkg;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: hex nibble to active-low gfedcba segments
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with brightness, blanking, blink and frame-synchronous update
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SUB_TICKS    = 3125,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] num,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);
  localparam int SW = cnt_w(SUB_TICKS);
  localparam int DW = cnt_w(N_DIGITS);
  localparam int BW = cnt_w(BLINK_FRAMES);
  localparam logic [N_DIGITS-1:0] AN_ALL = AN_OFF[N_DIGITS-1:0];
  logic [SW-1:0] sub_q, sub_d;
  logic [3:0] phase_q, phase_d;
  logic [DW-1:0] sel_q, sel_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic blink_q, blink_d;
  logic [4*N_DIGITS-1:0] pend_q, pend_d, act_q, act_d;
  logic [N_DIGITS-1:0] pdp_q, pdp_d, adp_q, adp_d, lz, an_q, an_d;
  logic [6:0] seg_q, seg_d, dec_seg;
  logic dp_q, dp_d, fd_q, fd_d;
  logic sub_tc, slot_end, frame_end, blink_tc, lit, nz;
  seg7_decode u_dec (
    .nib (act_q[4*sel_q +: 4]),
    .seg (dec_seg)
  );
  // Scan counters, blink timer and shadow/active display registers; a load on the frame-end cycle bypasses pending
  always_comb begin
    sub_tc    = sub_q == SW'(SUB_TICKS - 1);
    slot_end  = sub_tc && phase_q == 4'hF;
    frame_end = slot_end && sel_q == DW'(N_DIGITS - 1);
    blink_tc  = bcnt_q == BW'(BLINK_FRAMES - 1);
    sub_d     = sub_tc ? '0 : sub_q + 1'b1;
    phase_d   = sub_tc ? phase_q + 4'd1 : phase_q;
    sel_d     = frame_end ? '0 : slot_end ? sel_q + 1'b1 : sel_q;
    bcnt_d    = !frame_end ? bcnt_q : blink_tc ? '0 : bcnt_q + 1'b1;
    blink_d   = blink_q ^ (frame_end && blink_tc);
    pend_d    = load ? num : pend_q;
    pdp_d     = load ? dp_in : pdp_q;
    act_d     = frame_end ? pend_d : act_q;
    adp_d     = frame_end ? pdp_d : adp_q;
    fd_d      = frame_end;
  end
  // Leading-zero mask: digit i blanks when it and every digit above it are zero; digit 0 never blanks
  always_comb begin
    lz = '0;
    nz = 1'b0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      nz    = nz | (act_q[4*i +: 4] != 4'h0);
      lz[i] = ~nz;
    end
  end
  // Next registered drive for the currently selected digit and brightness phase
  always_comb begin
    lit   = digit_en[sel_q] && !(blank_lz && lz[sel_q]) && !(blink_q && blink_mask[sel_q]) && phase_q <= bright;
    seg_d = lit ? dec_seg : SEG_OFF;
    dp_d  = lit ? ~adp_q[sel_q] : 1'b1;
    an_d  = lit ? ~(N_DIGITS'(1) << sel_q) : AN_ALL;
  end
  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      sub_q   <= '0;
      phase_q <= '0;
      sel_q   <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      pend_q  <= '0;
      pdp_q   <= '0;
      act_q   <= '0;
      adp_q   <= '0;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      an_q    <= AN_ALL;
      fd_q    <= 1'b0;
    end else begin
      sub_q   <= sub_d;
      phase_q <= phase_d;
      sel_q   <= sel_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      pend_q  <= pend_d;
      pdp_q   <= pdp_d;
      act_q   <= act_d;
      adp_q   <= adp_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end
  assign seg        = seg_q;
  assign dp_n       = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed scoreboard bench for seg7_scan_ctrl (N=4, SUB_TICKS=2, BLINK_FRAMES=2)
module tb_seg7_scan_ctrl;
  typedef struct {
    int         k;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] num = '0;
  logic load = 1'b0;
  logic [3:0] dp_in = '0;
  logic [3:0] digit_en = 4'hF;
  logic blank_lz = 1'b0;
  logic [3:0] bright = 4'hF;
  logic [3:0] blink_mask = '0;
  logic [6:0] seg;
  logic dp_n;
  logic [3:0] an;
  logic frame_done;
  int k = 0;
  int passed = 0;
  int total = 0;
  int fails = 0;
  exp_t sb[$];
  exp_t e;
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  seg7_scan_ctrl #(.N_DIGITS(4), .SUB_TICKS(2), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .num        (num),
    .load       (load),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .bright     (bright),
    .blink_mask (blink_mask),
    .seg        (seg),
    .dp_n       (dp_n),
    .an         (an),
    .frame_done (frame_done)
  );
  always #5 clk = ~clk;
  // k = number of rising edges since reset release; output after edge k reflects scan cycle k-1
  always @(posedge clk) k <= rst ? k + 1 : 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input int kk, input logic [3:0] a, input logic [6:0] s, input logic d, input logic f);
    sb.push_back('{kk, a, s, d, f});
  endtask
  task automatic at(input int kk);
    while (k < kk) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].k <= k) begin
      e = sb.pop_front();
      chk($sformatf("when@%0d", e.k), k, e.k);
      chk($sformatf("an@%0d", e.k), an, e.an);
      chk($sformatf("seg@%0d", e.k), seg, e.seg);
      chk($sformatf("dp@%0d", e.k), dp_n, e.dp);
      chk($sformatf("fd@%0d", e.k), frame_done, e.fd);
    end
  end
  initial begin
    logic [15:0] v;
    logic [3:0] dpv, oh;
    v = 16'h12AF;
    dpv = 4'b0100;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp_n, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    rst = 1'b1;
    push(1, 4'hE, 7'h40, 1'b1, 1'b0);
    push(128, 4'h7, 7'h40, 1'b1, 1'b1);
    for (int d = 0; d < 4; d++) begin
      oh = 4'b0001 << d;
      push(132 + 32 * d, ~oh, tbl[v[4*d +: 4]], ~dpv[d], 1'b0);
    end
    push(256, 4'h7, 7'h79, 1'b1, 1'b1);
    push(264, 4'hE, 7'h0E, 1'b1, 1'b0);
    push(265, 4'hF, 7'h7F, 1'b1, 1'b0);
    push(321, 4'hB, 7'h24, 1'b0, 1'b0);
    push(329, 4'hF, 7'h7F, 1'b1, 1'b0);
    at(9);
    load = 1'b1; num = 16'h3333; dp_in = 4'hF;
    at(10);
    load = 1'b0;
    at(19);
    load = 1'b1; num = v; dp_in = dpv;
    at(20);
    load = 1'b0; num = '0; dp_in = '0;
    at(256);
    bright = 4'd3;
    at(384);
    bright = 4'hF;
    push(427, 4'hD, 7'h08, 1'b1, 1'b0);
    push(484, 4'h7, 7'h79, 1'b1, 1'b0);
    push(516, 4'hE, 7'h79, 1'b1, 1'b0);
    push(548, 4'hD, 7'h79, 1'b1, 1'b0);
    at(421);
    load = 1'b1; num = 16'h1111; dp_in = '0;
    at(422);
    load = 1'b0; num = '0;
    push(640, 4'h7, 7'h79, 1'b1, 1'b1);
    push(644, 4'hE, 7'h40, 1'b1, 1'b0);
    push(676, 4'hD, 7'h12, 1'b1, 1'b0);
    push(708, 4'hF, 7'h7F, 1'b1, 1'b0);
    push(740, 4'hF, 7'h7F, 1'b1, 1'b0);
    at(639);
    load = 1'b1; num = 16'h0050; blank_lz = 1'b1;
    at(640);
    load = 1'b0; num = '0;
    push(772, 4'hF, 7'h7F, 1'b1, 1'b0);
    push(804, 4'hF, 7'h7F, 1'b1, 1'b0);
    push(836, 4'hB, 7'h40, 1'b1, 1'b0);
    push(900, 4'hF, 7'h7F, 1'b1, 1'b0);
    push(932, 4'hD, 7'h12, 1'b1, 1'b0);
    push(1028, 4'hE, 7'h40, 1'b1, 1'b0);
    push(1060, 4'hD, 7'h12, 1'b1, 1'b0);
    at(767);
    blink_mask = 4'b0001; digit_en = 4'b1101; blank_lz = 1'b0;
    at(895);
    digit_en = 4'hF;
    at(1090);
    load = 1'b1; num = 16'h7777; dp_in = 4'hF;
    at(1091);
    load = 1'b0; num = '0; dp_in = '0;
    at(1095);
    chk("pre_rst_drain", sb.size(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_dp", dp_n, 1'b1);
    chk("mid_rst_fd", frame_done, 1'b0);
    rst = 1'b1;
    push(1, 4'hE, 7'h40, 1'b1, 1'b0);
    push(128, 4'h7, 7'h40, 1'b1, 1'b1);
    push(132, 4'hE, 7'h40, 1'b1, 1'b0);
    push(164, 4'hD, 7'h40, 1'b1, 1'b0);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
